// File: rtl/perceptron_bht_pkg.sv
// Shared types for the perceptron branch predictor.
//   riscv          : address width of the fetch PC (VLEN).
//   ariane_pbp_pkg : update/prediction bus structs, predictor config struct,
//                    its default value, FSM state type and the default
//                    training-threshold helper.
package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pbp_pkg;

    // Resolved branch coming back from the backend.
    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } bht_update_t;

    // Direction prediction for the current fetch PC.
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    // Perceptron geometry and training threshold.
    typedef struct packed {
        int unsigned nr_entries;
        int unsigned hist_len;
        int unsigned weight_w;
        int unsigned theta;
    } pbp_cfg_t;

    localparam pbp_cfg_t PbpDefaultCfg = '{
        nr_entries: 64,
        hist_len:   16,
        weight_w:   8,
        theta:      44
    };

    typedef enum logic {
        PbpInit,
        PbpRun
    } pbp_state_e;

    // floor(1.93 * hist_len) + 14, in integer arithmetic.
    function automatic int unsigned pbp_default_theta(input int unsigned hist_len);
        return (hist_len * 193) / 100 + 14;
    endfunction

endpackage

// File: rtl/perceptron_bht_if.sv
// Bundle of the predictor's fetch-side and update-side signals.
//   vpc            : fetch PC to predict
//   bht_update     : resolved branch outcome
//   bht_prediction : direction prediction for vpc
// master drives PC and updates and receives predictions; slave is the predictor.
interface perceptron_bht_if;
    import ariane_pbp_pkg::*;

    logic [riscv::VLEN-1:0] vpc;
    bht_update_t            bht_update;
    bht_prediction_t        bht_prediction;

    modport master (
        output vpc,
        output bht_update,
        input  bht_prediction
    );

    modport slave (
        input  vpc,
        input  bht_update,
        output bht_prediction
    );

endinterface

// File: rtl/perceptron_bht_dot.sv
// Combinational perceptron dot product.
//   weights_i : row of HistLen+1 signed weights, element 0 is the bias w0
//   ghr_i     : global history, bit i selects +w(i+1) when set, -w(i+1) when clear
//   sum_o     : signed sum, wide enough that it can never overflow
module perceptron_dot #(
    parameter int unsigned HistLen = 16,
    parameter int unsigned WeightW = 8,
    parameter int unsigned SumW    = 14
) (
    input  logic [HistLen:0][WeightW-1:0] weights_i,
    input  logic [HistLen-1:0]            ghr_i,
    output logic signed [SumW-1:0]        sum_o
);

    localparam int unsigned IW = $clog2(HistLen + 1);
    localparam int unsigned GW = (HistLen > 1) ? $clog2(HistLen) : 1;

    function automatic logic signed [SumW-1:0] sext(input logic [WeightW-1:0] w);
        return $signed({{(SumW - WeightW){w[WeightW-1]}}, w});
    endfunction

    logic signed [SumW-1:0] acc;

    always_comb begin
        acc = sext(weights_i[0]);
        for (int unsigned i = 0; i < HistLen; i++) begin
            if (ghr_i[GW'(i)]) begin
                acc = acc + sext(weights_i[IW'(i + 1)]);
            end else begin
                acc = acc - sext(weights_i[IW'(i + 1)]);
            end
        end
        sum_o = acc;
    end

endmodule

// File: rtl/perceptron_bht.sv
// Perceptron branch direction predictor with a non-speculative global history.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : clears history and re-zeroes the weight table
//   debug_mode_i      : blocks training and history updates while high
//   vpc_i             : fetch PC, predicted combinationally in the same cycle
//   bht_update_i      : resolved branch; trains the row selected by its PC
//   bht_prediction_o  : valid once the table sweep is done, taken = (sum >= 0)
// After reset or flush the table is zeroed one row per cycle (INIT), then the
// predictor runs (RUN). The table is flops with one write and two read ports.
module perceptron_bht
    import ariane_pbp_pkg::*;
#(
    parameter int unsigned NrEntries = PbpDefaultCfg.nr_entries,
    parameter int unsigned HistLen   = PbpDefaultCfg.hist_len,
    parameter int unsigned WeightW   = PbpDefaultCfg.weight_w,
    parameter int unsigned Theta     = pbp_default_theta(HistLen)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    input  logic [riscv::VLEN-1:0] vpc_i,
    input  bht_update_t            bht_update_i,
    output bht_prediction_t        bht_prediction_o
);

    localparam int unsigned IdxW = $clog2(NrEntries);
    localparam int unsigned SumW = WeightW + $clog2(HistLen + 1) + 1;
    localparam int unsigned IW   = $clog2(HistLen + 1);
    localparam int unsigned GW   = (HistLen > 1) ? $clog2(HistLen) : 1;

    typedef logic [HistLen:0][WeightW-1:0] row_t;

    localparam logic [WeightW-1:0] WMax = {1'b0, {(WeightW - 1){1'b1}}};
    localparam logic [WeightW-1:0] WMin = {1'b1, {(WeightW - 1){1'b0}}};

    pbp_state_e        state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic [HistLen-1:0] ghr_q, ghr_d;
    row_t              table_q [NrEntries];
    row_t              table_d [NrEntries];

    logic [IdxW-1:0]        pred_idx, upd_idx;
    logic signed [SumW-1:0] pred_sum, upd_sum;
    logic                   accept, train;
    int unsigned            sum_mag;
    row_t                   upd_row_new;
    logic                   unused_bits;

    assign pred_idx = vpc_i[IdxW:1];
    assign upd_idx  = bht_update_i.pc[IdxW:1];

    assign unused_bits = ^{vpc_i[riscv::VLEN-1:IdxW+1], vpc_i[0],
                           bht_update_i.pc[riscv::VLEN-1:IdxW+1], bht_update_i.pc[0]};

    perceptron_dot #(
        .HistLen (HistLen),
        .WeightW (WeightW),
        .SumW    (SumW)
    ) u_dot_pred (
        .weights_i (table_q[pred_idx]),
        .ghr_i     (ghr_q),
        .sum_o     (pred_sum)
    );

    perceptron_dot #(
        .HistLen (HistLen),
        .WeightW (WeightW),
        .SumW    (SumW)
    ) u_dot_upd (
        .weights_i (table_q[upd_idx]),
        .ghr_i     (ghr_q),
        .sum_o     (upd_sum)
    );

    // Step a weight by +/-1, sticking at the two's-complement limits.
    function automatic logic [WeightW-1:0] sat_step(input logic [WeightW-1:0] w,
                                                    input logic             inc);
        if (inc) begin
            return (w == WMax) ? w : w + WeightW'(1);
        end
        return (w == WMin) ? w : w - WeightW'(1);
    endfunction

    // Training decision and the trained row, both from the pre-update GHR.
    always_comb begin
        accept  = (state_q == PbpRun) && bht_update_i.valid && !debug_mode_i;
        sum_mag = upd_sum[SumW-1] ? unsigned'(-int'(upd_sum)) : unsigned'(int'(upd_sum));
        train   = (!upd_sum[SumW-1] != bht_update_i.taken) || (sum_mag <= Theta);

        // w0 moves toward the outcome; wi moves up when history bit agrees with it.
        upd_row_new    = table_q[upd_idx];
        upd_row_new[0] = sat_step(table_q[upd_idx][0], bht_update_i.taken);
        for (int unsigned i = 0; i < HistLen; i++) begin
            upd_row_new[IW'(i + 1)] = sat_step(table_q[upd_idx][IW'(i + 1)],
                                               ghr_q[GW'(i)] == bht_update_i.taken);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ghr_d   = ghr_q;
        table_d = table_q;

        if (flush_i) begin
            state_d = PbpInit;
            cnt_d   = '0;
            ghr_d   = '0;
        end else begin
            case (state_q)
                PbpInit: begin
                    table_d[cnt_q] = '0;
                    cnt_d          = cnt_q + IdxW'(1);
                    if (cnt_q == IdxW'(NrEntries - 1)) begin
                        state_d = PbpRun;
                    end
                end
                PbpRun: begin
                    if (accept) begin
                        ghr_d = HistLen'({ghr_q, bht_update_i.taken});
                        if (train) begin
                            table_d[upd_idx] = upd_row_new;
                        end
                    end
                end
                default: state_d = PbpInit;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PbpInit;
            cnt_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ghr_q   <= ghr_d;
        end
    end

    // Weights carry no reset; the INIT sweep clears them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            table_q <= table_d;
        end
    end

    always_comb begin
        bht_prediction_o.valid = (state_q == PbpRun);
        bht_prediction_o.taken = (state_q == PbpRun) ? ~pred_sum[SumW-1] : 1'b1;
    end

endmodule

// File: tb/tb_perceptron_bht.sv
// Bench for perceptron_bht: a default instance and a WeightW=4/Theta=255
// instance share stimulus and are both compared each cycle against an
// integer-arithmetic perceptron model.
module tb_perceptron_bht;
    import ariane_pbp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, dbg, upd_v, upd_tk;
    logic [63:0] upd_pc, vpc;

    perceptron_bht_if bus_a ();
    perceptron_bht_if bus_b ();

    assign bus_a.vpc        = vpc;
    assign bus_a.bht_update = {upd_v, upd_pc, upd_tk};
    assign bus_b.vpc        = vpc;
    assign bus_b.bht_update = {upd_v, upd_pc, upd_tk};

    perceptron_bht dut_a (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .debug_mode_i     (dbg),
        .vpc_i            (bus_a.vpc),
        .bht_update_i     (bus_a.bht_update),
        .bht_prediction_o (bus_a.bht_prediction)
    );

    perceptron_bht #(
        .WeightW (4),
        .Theta   (255)
    ) dut_b (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .debug_mode_i     (dbg),
        .vpc_i            (bus_b.vpc),
        .bht_update_i     (bus_b.bht_update),
        .bht_prediction_o (bus_b.bht_prediction)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model (index 0: default, 1: narrow) -------------
    int          mw [2][64][17];
    logic [15:0] mghr [2];
    bit          mrun [2];
    int          mleft [2];
    bit          mtrained [2];
    bit          mknown = 0;

    function automatic int wbits(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int theta(input int k);
        return (k == 0) ? 44 : 255;
    endfunction

    function automatic int clamp(input int k, input int v);
        int hi = (1 << (wbits(k) - 1)) - 1;
        int lo = -(1 << (wbits(k) - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int msum(input int k, input int r);
        int s = mw[k][r][0];
        for (int i = 0; i < 16; i++) begin
            s += mghr[k][i] ? mw[k][r][i+1] : -mw[k][r][i+1];
        end
        return s;
    endfunction

    function automatic logic [135:0] pack_row(input int k, input int r);
        logic [135:0] p = '0;
        logic [31:0]  v;
        for (int j = 0; j < 17; j++) begin
            v = mw[k][r][j];
            for (int b = 0; b < wbits(k); b++) begin
                p[j * wbits(k) + b] = v[b];
            end
        end
        return p;
    endfunction

    task automatic model_step(input int k);
        int r, s, t, mag;
        mtrained[k] = 0;
        if (rst || flush) begin
            mrun[k]  = 0;
            mleft[k] = 64;
            mghr[k]  = '0;
        end else if (!mrun[k]) begin
            mleft[k]--;
            if (mleft[k] == 0) begin
                mrun[k] = 1;
                for (int a = 0; a < 64; a++)
                    for (int j = 0; j < 17; j++)
                        mw[k][a][j] = 0;
            end
        end else if (upd_v && !dbg) begin
            r   = int'(upd_pc[6:1]);
            s   = msum(k, r);
            t   = upd_tk ? 1 : -1;
            mag = (s < 0) ? -s : s;
            if (((s >= 0) != upd_tk) || (mag <= theta(k))) begin
                mtrained[k] = 1;
                mw[k][r][0] = clamp(k, mw[k][r][0] + t);
                for (int i = 0; i < 16; i++) begin
                    mw[k][r][i+1] = clamp(k, mw[k][r][i+1] + (mghr[k][i] ? t : -t));
                end
            end
            mghr[k] = {mghr[k][14:0], upd_tk};
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) mknown = 1;
    end

    // ---------------- per-cycle comparison ----------------
    task automatic cmp_dut(input int k, input logic v, input logic tk,
                           input logic [15:0] g, input logic [135:0] row);
        int r = int'(vpc[6:1]);
        check($sformatf("valid[%0d]", k), 136'(v), 136'(mrun[k]));
        check($sformatf("taken[%0d]", k), 136'(tk), 136'(mrun[k] ? (msum(k, r) >= 0) : 1'b1));
        check($sformatf("ghr[%0d]", k), 136'(g), 136'(mghr[k]));
        if (mrun[k]) begin
            check($sformatf("row[%0d][%0d]", k, r), row, pack_row(k, r));
        end
    endtask

    always @(negedge clk) begin
        if (mknown) begin
            cmp_dut(0, bus_a.bht_prediction.valid, bus_a.bht_prediction.taken,
                    dut_a.ghr_q, 136'(dut_a.table_q[vpc[6:1]]));
            cmp_dut(1, bus_b.bht_prediction.valid, bus_b.bht_prediction.taken,
                    dut_b.ghr_q, 136'(dut_b.table_q[vpc[6:1]]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic [63:0] pc, input logic tk);
        upd_v  = v;
        upd_pc = pc;
        upd_tk = tk;
        @(posedge clk);
        #1;
        upd_v = 1'b0;
    endtask

    initial begin
        int row;
        int w0_save;

        rst = 1'b1; flush = 1'b0; dbg = 1'b0;
        upd_v = 1'b0; upd_pc = '0; upd_tk = 1'b0; vpc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 136'(bus_a.bht_prediction.valid), 136'(1'b0));
        check("rst_taken", 136'(bus_a.bht_prediction.taken), 136'(1'b1));

        // Sweep: valid rises exactly after the 64th edge.
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            if (c == 63) check("sweep_valid63", 136'(bus_a.bht_prediction.valid), 136'(1'b0));
            if (c == 64) begin
                check("sweep_valid64", 136'(bus_a.bht_prediction.valid), 136'(1'b1));
                check("sweep_taken64", 136'(bus_a.bht_prediction.taken), 136'(1'b1));
            end
        end

        // Three not-taken updates train w0 to -3.
        repeat (3) cyc(1'b1, 64'h8000_0000, 1'b0);
        vpc = 64'h8000_0000;
        #1;
        check("train_w0", 136'(dut_a.table_q[0][0]), 136'(8'hFD));
        check_int("model_w0", mw[0][0][0], -3);
        check("train_ghr", 136'(dut_a.ghr_q), 136'(16'h0));
        check("train_taken", 136'(bus_a.bht_prediction.taken), 136'(1'b0));

        // Same-cycle update and predict on row 0.
        vpc    = 64'h100;
        upd_v  = 1'b1;
        upd_pc = 64'h100;
        upd_tk = 1'b1;
        #1;
        check("samecyc_taken", 136'(bus_a.bht_prediction.taken), 136'(1'b0));
        check("samecyc_w0_old", 136'(dut_a.table_q[0][0]), 136'(8'hFD));
        @(posedge clk);
        #1;
        upd_v = 1'b0;
        check("samecyc_w0_new", 136'(dut_a.table_q[0][0]), 136'(8'hFE));
        check("samecyc_ghr", 136'(dut_a.ghr_q), 136'(16'h1));

        // Flush mid-RUN.
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ghr", 136'(dut_a.ghr_q), 136'(16'h0));
        check("flush_valid0", 136'(bus_a.bht_prediction.valid), 136'(1'b0));
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("flush_valid%0d", c), 136'(bus_a.bht_prediction.valid), 136'(c == 64));
        end

        // Threshold: repeated taken updates converge, then only GHR moves.
        vpc = 64'h40;
        for (int n = 1; n <= 60; n++) begin
            cyc(1'b1, 64'h40, 1'b1);
            if (n > 57) check_int($sformatf("thr_no_train%0d", n), int'(mtrained[0]), 0);
        end
        check_int("thr_sum_above", int'(msum(0, 32) > 44), 1);
        check("thr_ghr", 136'(dut_a.ghr_q), 136'(16'hFFFF));

        // Debug mode: updates are ignored entirely.
        w0_save = mw[0][32][0];
        dbg = 1'b1;
        repeat (5) cyc(1'b1, 64'h40, 1'b0);
        dbg = 1'b0;
        check("dbg_ghr", 136'(dut_a.ghr_q), 136'(16'hFFFF));
        check("dbg_w0", 136'(dut_a.table_q[32][0]), 136'(8'(w0_save)));

        // Saturation on the 4-bit instance with history all ones.
        vpc = 64'h7E;
        repeat (20) cyc(1'b1, 64'h7E, 1'b1);
        for (int j = 0; j < 17; j++) begin
            check($sformatf("sat_w%0d", j), 136'(dut_b.table_q[63][j]), 136'(4'h7));
        end

        // Randomized traffic over a handful of rows with biased outcomes.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 999) == 0);
            flush = ($urandom_range(0, 199) == 0);
            dbg   = ($urandom_range(0, 9) == 0);
            upd_v = 1'($urandom_range(0, 1));
            upd_pc = {$urandom, $urandom};
            row    = int'($urandom_range(0, 7));
            upd_pc[6:1] = 6'(row);
            upd_tk = (row % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            vpc = {$urandom, $urandom};
            vpc[6:1] = 6'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        rst = 1'b0; flush = 1'b0; dbg = 1'b0; upd_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perceptron_bht.md
PERCEPTRON_BHT -- requirements
Module: perceptron_bht

Interface
REQ-001 SHALL have parameter NrEntries, default 64, number of perceptron rows, power of two, at least 2.
REQ-002 SHALL have parameter HistLen, default 16, global history length in bits, 1..32.
REQ-003 SHALL have parameter WeightW, default 8, signed two's-complement weight width, 3..16.
REQ-004 SHALL have parameter Theta, default floor(1.93*HistLen)+14 (44 at default), the training threshold.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port flush_i, input, 1, clears the predictor state.
REQ-008 SHALL have port debug_mode_i, input, 1, suppresses training while high.
REQ-009 SHALL have port vpc_i, input, riscv::VLEN, the fetch PC to predict.
REQ-010 SHALL have port bht_update_i, input, bht_update_t, the resolved branch outcome.
REQ-011 SHALL have port bht_prediction_o, output, bht_prediction_t, the direction prediction for vpc_i.

Function
REQ-012 SHALL compute the row index as vpc_i[log2(NrEntries):1]; the update index SHALL be computed the same way from bht_update_i.pc.
REQ-013 SHALL hold per row one bias weight w0 and HistLen weights wi, each WeightW bits.
REQ-014 SHALL keep a HistLen-bit global history register (GHR), non-speculative, with bit 0 the newest outcome.
REQ-015 SHALL compute the prediction combinationally in the same cycle as vpc_i: sum = w0 + sum over i of (GHR[i] ? +wi : -wi); taken = (sum >= 0).
REQ-016 SHALL size the sum WeightW + clog2(HistLen+1) + 1 bits signed, so it never overflows.
REQ-017 SHALL use a two-state FSM, INIT and RUN; INIT sweeps a row counter 0..NrEntries-1, zeroing one row per cycle, then moves to RUN.
REQ-018 SHALL drive bht_prediction_o.valid = 0 in INIT and = 1 in RUN.
REQ-019 SHALL, in RUN with bht_update_i.valid=1 and debug_mode_i=0, recompute the sum for the update row using the pre-update GHR.
REQ-020 SHALL train the row when (sum >= 0) != taken, or |sum| <= Theta: with t = +1 if taken else -1, w0 += t and wi += (GHR[i] ? t : -t).
REQ-021 SHALL clamp every trained weight to [-2^(WeightW-1), 2^(WeightW-1)-1].
REQ-022 SHALL write the weights and shift taken into GHR[0] at the same clock edge; GHR SHALL shift on every accepted update, whether or not it trains.
REQ-023 SHALL give a same-cycle predict to the row being updated the old weights and old GHR; the new values are visible the next cycle.
REQ-024 SHALL ignore updates in INIT; with debug_mode_i=1, updates SHALL change neither the weights nor the GHR.
REQ-025 SHALL, on flush_i in any state, clear the GHR, reset the sweep counter to 0 and enter INIT; flush takes precedence over a same-cycle update.

Reset
REQ-026 SHALL, on rst_i=1, set FSM=INIT, sweep counter=0 and GHR=0; outputs SHALL then be valid=0, taken=1.
REQ-027 SHALL take NrEntries cycles after reset release for the table to become all-zero; reset asserted during a sweep SHALL restart the sweep at row 0.

Structure
REQ-028 SHALL take bht_update_t and bht_prediction_t from ariane_pbp_pkg, and ariane_pbp_pkg SHALL add a perceptron config struct (NrEntries, HistLen, WeightW, Theta) plus a default constant.
REQ-029 SHALL place the dot product in a sub-module perceptron_dot, combinational, taking weights and GHR and returning sum; it SHALL be instantiated twice, once for predict and once for update.
REQ-030 SHALL hold the weight table in flops, one write port and two read ports.

Verification
REQ-031 Reset and sweep, default params: 64 cycles after reset valid=0; cycle 65 valid=1, taken=1 (sum=0).
REQ-032 Training: 3 not-taken updates at pc 0x80000000 -> w0=-3, GHR=0, and a predict at the same pc gives taken=0.
REQ-033 Same-cycle update and predict at pc 0x100 -> prediction equals the pre-update value, and the updated value appears the next cycle.
REQ-034 Saturation: WeightW=4, Theta=255, 20 taken updates at one pc -> w0=7 and every wi=7, never wrapping to -8.
REQ-035 Threshold: default params, repeated taken updates at one pc -> training stops once sum > 44, and further updates change only the GHR.
REQ-036 Flush and debug: flush_i mid-RUN -> valid=0 for 64 cycles and GHR=0; updates with debug_mode_i=1 -> weights and GHR unchanged.
